fifo_sc_flex: RTL and testbench

- Behavioural, vendor-independent single-clock FIFO that replaces primitive-based FIFOs wherever portability or extra status is needed.
- Generic item type and any depth ≥ 2, not only powers of two.
- Selectable read mode: first-word-fall-through (FWFT) or standard registered read.
- Status outputs: runtime-programmable almost-full/almost-empty, sticky overflow/underflow, and a reset-busy window.
- Sits between stream producers and consumers inside one clock domain.

---
 rtl/fifo_sc_flex.sv | 210 +++++++++++++++++++++
 tb/tb_fifo_sc_flex.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_sc_flex.sv
// rtl/fifo_sc_flex.sv - behavioural single-clock FIFO with FWFT/standard read and status flags
// Optional feature macro: FIFO_SC_FLEX_WATERMARK_EN (adds peak occupancy tracking).

module fifo_sc_flex #(
    parameter type DATA_ITEM_TYPE = logic,
    parameter int  DEPTH          = 32,
    parameter int  FWFT           = 1,
    parameter int  RST_HOLD       = 2,
    localparam int DATA_COUNT_W   = $clog2(DEPTH + 1)
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  DATA_ITEM_TYPE           i_tail,
    input  logic                    i_push,
    output DATA_ITEM_TYPE           o_head,
    output logic                    o_head_valid,
    input  logic                    i_pop,
    output logic                    o_full,
    output logic                    o_empty,
    output logic [DATA_COUNT_W-1:0] o_data_count,
    input  logic [DATA_COUNT_W-1:0] i_afull_thresh,
    input  logic [DATA_COUNT_W-1:0] i_aempty_thresh,
    output logic                    o_almost_full,
    output logic                    o_almost_empty,
    output logic                    o_overflow,
    output logic                    o_underflow,
    input  logic                    i_clr_err,
`ifdef FIFO_SC_FLEX_WATERMARK_EN
    input  logic                    i_peak_clr,
    output logic [DATA_COUNT_W-1:0] o_peak_count,
`endif
    output logic                    o_rst_busy
);

    // Pointers only need to address DEPTH entries; DEPTH need not be a power of two.
    localparam int PTR_W  = $clog2(DEPTH);
    // Hold counter is at least one bit wide so RST_HOLD = 0 still elaborates.
    localparam int HOLD_W = (RST_HOLD > 0) ? $clog2(RST_HOLD + 1) : 1;

    localparam logic [PTR_W-1:0]        LAST_IDX = PTR_W'(DEPTH - 1);
    localparam logic [DATA_COUNT_W-1:0] FULL_CNT = DATA_COUNT_W'(DEPTH);
    localparam logic [DATA_COUNT_W-1:0] ONE_CNT  = DATA_COUNT_W'(1);

    if (DEPTH < 2) begin : g_bad_depth
        $error("fifo_sc_flex: DEPTH must be at least 2");
    end
    if (RST_HOLD < 0) begin : g_bad_hold
        $error("fifo_sc_flex: RST_HOLD must not be negative");
    end

    // Storage and bookkeeping state.
    DATA_ITEM_TYPE             r_mem [DEPTH];
    DATA_ITEM_TYPE             r_head;
    logic [PTR_W-1:0]          r_wr_ptr;
    logic [PTR_W-1:0]          r_rd_ptr;
    logic [DATA_COUNT_W-1:0]   r_count;
    logic                      r_full;
    logic                      r_empty;
    logic                      r_afull;
    logic                      r_aempty;
    logic                      r_overflow;
    logic                      r_underflow;
    logic                      r_busy;
    logic [HOLD_W-1:0]         r_hold;

    logic                      w_wr_acc;
    logic                      w_rd_acc;
    logic                      w_ov_set;
    logic                      w_un_set;
    logic [DATA_COUNT_W-1:0]   w_count_next;
    logic [PTR_W-1:0]          w_wr_ptr_next;
    logic [PTR_W-1:0]          w_rd_ptr_next;
    DATA_ITEM_TYPE             w_mem_rd;

    // Accept decisions use registered flags only, so a same-cycle pop never frees
    // room for a push and a same-cycle push never feeds a pop.
    assign w_wr_acc = i_push & ~r_full  & ~r_busy;
    assign w_rd_acc = i_pop  & ~r_empty & ~r_busy;
    assign w_ov_set = i_push &  r_full  & ~r_busy;
    assign w_un_set = i_pop  &  r_empty & ~r_busy;

    // Explicit wrap compare keeps non-power-of-two depths correct.
    assign w_wr_ptr_next = (r_wr_ptr == LAST_IDX) ? '0 : r_wr_ptr + PTR_W'(1);
    assign w_rd_ptr_next = (r_rd_ptr == LAST_IDX) ? '0 : r_rd_ptr + PTR_W'(1);

    assign w_mem_rd = r_mem[r_rd_ptr];

    // Occupancy after this edge; simultaneous accepted push and pop cancel.
    always_comb begin
        w_count_next = r_count;
        if (w_wr_acc && !w_rd_acc) begin
            w_count_next = r_count + ONE_CNT;
        end else if (!w_wr_acc && w_rd_acc) begin
            w_count_next = r_count - ONE_CNT;
        end
    end

    // Reset-busy window: loaded during reset, counts down after release.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_busy <= 1'b1;
            r_hold <= HOLD_W'(RST_HOLD);
        end else begin
            r_busy <= (r_hold != '0);
            if (r_hold != '0) begin
                r_hold <= r_hold - HOLD_W'(1);
            end
        end
    end

    // Storage write; contents are not reset, the pointers and count discard them.
    always_ff @(posedge i_clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= i_tail;
        end
    end

    // Pointers, count and occupancy flags, all registered from the next count.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_afull  <= (i_afull_thresh == '0);
            r_aempty <= 1'b1;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= w_wr_ptr_next;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= w_rd_ptr_next;
            end
            r_count  <= w_count_next;
            r_full   <= (w_count_next == FULL_CNT);
            r_empty  <= (w_count_next == '0);
            r_afull  <= (w_count_next >= i_afull_thresh);
            r_aempty <= (w_count_next <= i_aempty_thresh);
        end
    end

    // Sticky error flags; a new error in the same cycle as clr_err wins.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= w_ov_set | (r_overflow  & ~i_clr_err);
            r_underflow <= w_un_set | (r_underflow & ~i_clr_err);
        end
    end

    // Last popped item: the registered head in standard mode, the held value
    // shown while empty in FWFT mode.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_head <= '0;
        end else if (w_rd_acc) begin
            r_head <= w_mem_rd;
        end
    end

    if (FWFT != 0) begin : g_fwft
        // Oldest entry is visible straight from storage whenever the FIFO holds data.
        assign o_head       = r_empty ? r_head : w_mem_rd;
        assign o_head_valid = ~r_empty;
    end else begin : g_std
        logic r_head_valid;

        // One-cycle valid pulse following each accepted pop.
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_head_valid <= 1'b0;
            end else begin
                r_head_valid <= w_rd_acc;
            end
        end

        assign o_head       = r_head;
        assign o_head_valid = r_head_valid;
    end

`ifdef FIFO_SC_FLEX_WATERMARK_EN
    logic [DATA_COUNT_W-1:0] r_peak;

    // High-water mark of occupancy; peak_clr restarts it from the current level.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_peak <= '0;
        end else if (i_peak_clr) begin
            r_peak <= w_count_next;
        end else if (w_count_next > r_peak) begin
            r_peak <= w_count_next;
        end
    end

    assign o_peak_count = r_peak;
`endif

    assign o_full         = r_full;
    assign o_empty        = r_empty;
    assign o_data_count   = r_count;
    assign o_almost_full  = r_afull;
    assign o_almost_empty = r_aempty;
    assign o_overflow     = r_overflow;
    assign o_underflow    = r_underflow;
    assign o_rst_busy     = r_busy;

endmodule

// File: tb/tb_fifo_sc_flex.sv
// tb/tb_fifo_sc_flex.sv - self-checking bench for fifo_sc_flex (depth 8/5 FWFT, depth 8 standard)

module tb_fifo_sc_flex;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, push, pop, clr_err;
    logic [7:0] tail;
    logic [3:0] a_afth, a_aeth, c_afth, c_aeth;
    logic [2:0] b_afth, b_aeth;
`ifdef FIFO_SC_FLEX_WATERMARK_EN
    logic       peak_clr;
    logic [3:0] a_peak, c_peak;
    logic [2:0] b_peak;
`endif

    logic [7:0] a_head, b_head, c_head;
    logic       a_hv, b_hv, c_hv, a_full, b_full, c_full, a_empty, b_empty, c_empty;
    logic [3:0] a_cnt, c_cnt;
    logic [2:0] b_cnt;
    logic       a_af, b_af, c_af, a_ae, b_ae, c_ae;
    logic       a_ov, b_ov, c_ov, a_un, b_un, c_un, a_busy, b_busy, c_busy;

    fifo_sc_flex #(.DATA_ITEM_TYPE(logic [7:0]), .DEPTH(8), .FWFT(1), .RST_HOLD(2)) u_a (
        .i_clk(clk), .i_rst(rst), .i_tail(tail), .i_push(push), .o_head(a_head),
        .o_head_valid(a_hv), .i_pop(pop), .o_full(a_full), .o_empty(a_empty),
        .o_data_count(a_cnt), .i_afull_thresh(a_afth), .i_aempty_thresh(a_aeth),
        .o_almost_full(a_af), .o_almost_empty(a_ae), .o_overflow(a_ov), .o_underflow(a_un),
        .i_clr_err(clr_err),
`ifdef FIFO_SC_FLEX_WATERMARK_EN
        .i_peak_clr(peak_clr), .o_peak_count(a_peak),
`endif
        .o_rst_busy(a_busy));

    fifo_sc_flex #(.DATA_ITEM_TYPE(logic [7:0]), .DEPTH(5), .FWFT(1), .RST_HOLD(2)) u_b (
        .i_clk(clk), .i_rst(rst), .i_tail(tail), .i_push(push), .o_head(b_head),
        .o_head_valid(b_hv), .i_pop(pop), .o_full(b_full), .o_empty(b_empty),
        .o_data_count(b_cnt), .i_afull_thresh(b_afth), .i_aempty_thresh(b_aeth),
        .o_almost_full(b_af), .o_almost_empty(b_ae), .o_overflow(b_ov), .o_underflow(b_un),
        .i_clr_err(clr_err),
`ifdef FIFO_SC_FLEX_WATERMARK_EN
        .i_peak_clr(peak_clr), .o_peak_count(b_peak),
`endif
        .o_rst_busy(b_busy));

    fifo_sc_flex #(.DATA_ITEM_TYPE(logic [7:0]), .DEPTH(8), .FWFT(0), .RST_HOLD(2)) u_c (
        .i_clk(clk), .i_rst(rst), .i_tail(tail), .i_push(push), .o_head(c_head),
        .o_head_valid(c_hv), .i_pop(pop), .o_full(c_full), .o_empty(c_empty),
        .o_data_count(c_cnt), .i_afull_thresh(c_afth), .i_aempty_thresh(c_aeth),
        .o_almost_full(c_af), .o_almost_empty(c_ae), .o_overflow(c_ov), .o_underflow(c_un),
        .i_clr_err(clr_err),
`ifdef FIFO_SC_FLEX_WATERMARK_EN
        .i_peak_clr(peak_clr), .o_peak_count(c_peak),
`endif
        .o_rst_busy(c_busy));

    int n_checks = 0;
    int n_pass   = 0;
    bit mon_en   = 1'b0;
    int b_max    = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    endtask

    // Reference model: each FIFO is a queue; flags follow from its size.
    logic [7:0] mq [3][$];
    int         m_depth [3] = '{8, 5, 8};
    int         m_fwft  [3] = '{1, 1, 0};
    bit         m_af [3], m_ae [3], m_ov [3], m_un [3], m_hv [3];
    logic [7:0] m_head [3];
    int         m_peak [3];
    bit         m_busy  = 1'b1;
    int         m_since = 0;

    function automatic int thr_af(input int i);
        case (i)
            0:       return int'(a_afth);
            1:       return int'(b_afth);
            default: return int'(c_afth);
        endcase
    endfunction

    function automatic int thr_ae(input int i);
        case (i)
            0:       return int'(a_aeth);
            1:       return int'(b_aeth);
            default: return int'(c_aeth);
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_busy  = 1'b1;
            m_since = 0;
            for (int i = 0; i < 3; i++) begin
                mq[i].delete();
                m_ov[i] = 0; m_un[i] = 0; m_hv[i] = 0; m_head[i] = 8'h00; m_peak[i] = 0;
                m_af[i] = (0 >= thr_af(i));
                m_ae[i] = 1'b1;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                automatic int         sz = mq[i].size();
                automatic bit         wr = push && !m_busy && (sz < m_depth[i]);
                automatic bit         rd = pop && !m_busy && (sz > 0);
                automatic bit         ovs = push && !m_busy && (sz == m_depth[i]);
                automatic bit         uns = pop && !m_busy && (sz == 0);
                automatic logic [7:0] pv = 8'h00;
                if (rd) pv = mq[i].pop_front();
                if (wr) mq[i].push_back(tail);
                if (m_fwft[i] == 0) begin
                    m_hv[i] = rd;
                    if (rd) m_head[i] = pv;
                end
                m_ov[i] = ovs || (m_ov[i] && !clr_err);
                m_un[i] = uns || (m_un[i] && !clr_err);
                sz = mq[i].size();
                m_af[i] = (sz >= thr_af(i));
                m_ae[i] = (sz <= thr_ae(i));
`ifdef FIFO_SC_FLEX_WATERMARK_EN
                if (peak_clr) m_peak[i] = sz;
                else if (sz > m_peak[i]) m_peak[i] = sz;
`endif
            end
            if (m_since < 1000) m_since++;
            m_busy = (m_since <= 2);
        end
    end

    task automatic check_inst(input int i, input string nm, input logic [7:0] head,
                              input logic hv, input logic full, input logic empty,
                              input logic [31:0] cnt, input logic af, input logic ae,
                              input logic ov, input logic un, input logic busy,
                              input logic [31:0] peak);
        automatic int sz = mq[i].size();
        chk({nm, ".count"}, cnt, 32'(sz));
        chk({nm, ".full"},  32'(full),  32'(sz == m_depth[i]));
        chk({nm, ".empty"}, 32'(empty), 32'(sz == 0));
        chk({nm, ".afull"}, 32'(af),    32'(m_af[i]));
        chk({nm, ".aempty"}, 32'(ae),   32'(m_ae[i]));
        chk({nm, ".overflow"}, 32'(ov), 32'(m_ov[i]));
        chk({nm, ".underflow"}, 32'(un), 32'(m_un[i]));
        chk({nm, ".rst_busy"}, 32'(busy), 32'(m_busy));
        if (m_fwft[i] == 0) begin
            chk({nm, ".head_valid"}, 32'(hv), 32'(m_hv[i]));
            chk({nm, ".head"}, 32'(head), 32'(m_head[i]));
        end else begin
            chk({nm, ".head_valid"}, 32'(hv), 32'(sz != 0));
            if (sz != 0) chk({nm, ".head"}, 32'(head), 32'(mq[i][0]));
        end
`ifdef FIFO_SC_FLEX_WATERMARK_EN
        chk({nm, ".peak"}, peak, 32'(m_peak[i]));
`endif
    endtask

    // Continuous comparison of all three FIFOs against the model.
    always @(negedge clk) begin
        if (mon_en) begin
            logic [31:0] pa, pb, pc;
            pa = 0; pb = 0; pc = 0;
`ifdef FIFO_SC_FLEX_WATERMARK_EN
            pa = 32'(a_peak); pb = 32'(b_peak); pc = 32'(c_peak);
`endif
            check_inst(0, "A", a_head, a_hv, a_full, a_empty, 32'(a_cnt), a_af, a_ae, a_ov, a_un, a_busy, pa);
            check_inst(1, "B", b_head, b_hv, b_full, b_empty, 32'(b_cnt), b_af, b_ae, b_ov, b_un, b_busy, pb);
            check_inst(2, "C", c_head, c_hv, c_full, c_empty, 32'(c_cnt), c_af, c_ae, c_ov, c_un, c_busy, pc);
            if (int'(b_cnt) > b_max) b_max = int'(b_cnt);
        end
    end

    task automatic cyc(input bit p, input bit q, input logic [7:0] d);
        push = p; pop = q; tail = d;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; push = 1'b0; pop = 1'b0; clr_err = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    typedef struct {
        bit         push;
        bit         pop;
        logic [7:0] tail;
        int         cnt;
        bit         ae;
        bit         af;
        bit         full;
        bit         empty;
        int         head;
    } vec_t;

    vec_t tbl [16];

    initial begin
        #200000;
        $display("FAIL timeout t=%0t", $time);
        $fatal(1);
    end

    initial begin
        rst = 1'b1; push = 1'b1; pop = 1'b1; tail = 8'h11; clr_err = 1'b0;
        a_afth = 4'd6; a_aeth = 4'd2; b_afth = 3'd4; b_aeth = 3'd1; c_afth = 4'd7; c_aeth = 4'd1;
`ifdef FIFO_SC_FLEX_WATERMARK_EN
        peak_clr = 1'b0;
`endif
        // Reset held 3 cycles with push and pop requested throughout.
        repeat (3) @(negedge clk);
        mon_en = 1'b1;
        chk("rst.busy", 32'(a_busy), 1);
        chk("rst.empty", 32'(a_empty), 1);
        chk("rst.full", 32'(a_full), 0);
        chk("rst.count", 32'(a_cnt), 0);
        chk("rst.head_valid", 32'(a_hv), 0);
        chk("rst.head", 32'(a_head), 0);
        chk("rst.aempty", 32'(a_ae), 1);
        chk("rst.afull", 32'(a_af), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("hold1.busy", 32'(a_busy), 1);
        @(negedge clk);
        chk("hold2.busy", 32'(a_busy), 1);
        @(negedge clk);
        chk("hold3.busy", 32'(a_busy), 0);
        chk("hold.count", 32'(a_cnt), 0);
        chk("hold.underflow", 32'(a_un), 0);

        // Fill 0..7 then drain, with thresholds afull=6 and aempty=2.
        for (int i = 0; i < 8; i++)
            tbl[i] = '{1'b1, 1'b0, 8'(i), i + 1, (i + 1) <= 2, (i + 1) >= 6, i == 7, 1'b0, 0};
        for (int j = 0; j < 8; j++)
            tbl[8 + j] = '{1'b0, 1'b1, 8'h00, 7 - j, (7 - j) <= 2, (7 - j) >= 6, 1'b0, j == 7, j + 1};
        for (int k = 0; k < 16; k++) begin
            cyc(tbl[k].push, tbl[k].pop, tbl[k].tail);
            chk($sformatf("tbl%0d.count", k), 32'(a_cnt), 32'(tbl[k].cnt));
            chk($sformatf("tbl%0d.aempty", k), 32'(a_ae), 32'(tbl[k].ae));
            chk($sformatf("tbl%0d.afull", k), 32'(a_af), 32'(tbl[k].af));
            chk($sformatf("tbl%0d.full", k), 32'(a_full), 32'(tbl[k].full));
            chk($sformatf("tbl%0d.empty", k), 32'(a_empty), 32'(tbl[k].empty));
            if (tbl[k].cnt != 0) chk($sformatf("tbl%0d.head", k), 32'(a_head), 32'(tbl[k].head));
        end

        // Overflow: push on full alone, then push together with an accepted pop.
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 8'(8'h20 + i));
        cyc(1'b1, 1'b0, 8'hEE);
        chk("ovf.flag", 32'(a_ov), 1);
        chk("ovf.count", 32'(a_cnt), 8);
        cyc(1'b1, 1'b1, 8'hEF);
        chk("ovf_pop.flag", 32'(a_ov), 1);
        chk("ovf_pop.count", 32'(a_cnt), 7);
        clr_err = 1'b1;
        cyc(1'b0, 1'b0, 8'h00);
        clr_err = 1'b0;
        chk("clr.overflow", 32'(a_ov), 0);
        for (int k = 0; k < 7; k++) begin
            chk($sformatf("ovf_drain%0d.head", k), 32'(a_head), 32'(8'h21 + k));
            cyc(1'b0, 1'b1, 8'h00);
        end
        chk("ovf_drain.empty", 32'(a_empty), 1);

        // Underflow: pop on empty with a same-cycle push, then set-beats-clear.
        cyc(1'b1, 1'b1, 8'h3C);
        chk("unf.flag", 32'(a_un), 1);
        chk("unf.count", 32'(a_cnt), 1);
        chk("unf.head", 32'(a_head), 32'(8'h3C));
        clr_err = 1'b1;
        cyc(1'b0, 1'b1, 8'h00);
        chk("unf_clr.flag", 32'(a_un), 0);
        chk("unf_clr.empty", 32'(a_empty), 1);
        cyc(1'b0, 1'b1, 8'h00);
        chk("unf_setwins.flag", 32'(a_un), 1);
        cyc(1'b0, 1'b0, 8'h00);
        chk("unf_clr2.flag", 32'(a_un), 0);
        chk("unf_clr2.ovf", 32'(a_ov), 0);
        clr_err = 1'b0;

        // Standard read mode on instance C.
        do_reset();
        chk("std.busy", 32'(c_busy), 0);
        cyc(1'b1, 1'b0, 8'hA5);
        chk("std_push.empty", 32'(c_empty), 0);
        chk("std_push.hv", 32'(c_hv), 0);
        cyc(1'b0, 1'b1, 8'h00);
        chk("std_pop.empty", 32'(c_empty), 1);
        chk("std_pop.hv", 32'(c_hv), 1);
        chk("std_pop.head", 32'(c_head), 32'(8'hA5));
        cyc(1'b0, 1'b0, 8'h00);
        chk("std_idle.hv", 32'(c_hv), 0);
        chk("std_idle.head", 32'(c_head), 32'(8'hA5));

        // Threshold change takes effect at the following edge.
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'(8'h50 + i));
        chk("thr5.count", 32'(a_cnt), 5);
        chk("thr5.afull", 32'(a_af), 0);
        a_afth = 4'd4;
        cyc(1'b0, 1'b0, 8'h00);
        chk("thr4.afull", 32'(a_af), 1);
        a_afth = 4'd6;

`ifdef FIFO_SC_FLEX_WATERMARK_EN
        do_reset();
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 8'(i));
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 8'h00);
        chk("wm.peak", 32'(a_peak), 6);
        chk("wm.count", 32'(a_cnt), 2);
        peak_clr = 1'b1;
        cyc(1'b0, 1'b0, 8'h00);
        peak_clr = 1'b0;
        chk("wm_clr.peak", 32'(a_peak), 2);
`endif

        // Randomized traffic alternating fill-biased and drain-biased phases.
        do_reset();
        for (int n = 0; n < 400; n++) begin
            automatic bit fill = ((n / 50) % 2) == 0;
            push    = $urandom_range(0, 99) < (fill ? 65 : 35);
            pop     = $urandom_range(0, 99) < (fill ? 35 : 65);
            tail    = 8'($urandom);
            clr_err = $urandom_range(0, 99) < 5;
            rst     = $urandom_range(0, 199) == 0;
`ifdef FIFO_SC_FLEX_WATERMARK_EN
            peak_clr = $urandom_range(0, 99) < 3;
`endif
            if ($urandom_range(0, 99) < 8) begin
                a_afth = 4'($urandom_range(0, 9)); a_aeth = 4'($urandom_range(0, 9));
                b_afth = 3'($urandom_range(0, 6)); b_aeth = 3'($urandom_range(0, 6));
                c_afth = 4'($urandom_range(0, 9)); c_aeth = 4'($urandom_range(0, 9));
            end
            @(negedge clk);
        end
        rst = 1'b0; push = 1'b0; pop = 1'b0; clr_err = 1'b0;
        @(negedge clk);
        chk("B.max_count_le_5", 32'(b_max <= 5), 1);
        chk("B.max_count_reached_5", 32'(b_max), 5);

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
